// File: rtl/birthday_digit_checker_if.sv
// Digit stream and status bundle between the display side and the birthday checker.
`default_nettype none

interface birthday_digit_checker_if #(
  parameter int CNT_W = 8
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             match;
  logic             error;
  logic             locked;
  logic [2:0]       pos;
  logic [CNT_W-1:0] match_count;

  modport master (
    output digit_valid, digit,
    input  match, error, locked, pos, match_count
  );

  modport slave (
    input  digit_valid, digit,
    output match, error, locked, pos, match_count
  );
endinterface

`default_nettype wire

// File: rtl/birthday_digit_checker.sv
// Checks an incoming BCD digit stream against an 8-digit birthday and counts complete matches.
`default_nettype none

module birthday_digit_checker #(
  parameter logic [31:0] BIRTHDAY = 32'h20010315,
  parameter int          CNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  birthday_digit_checker_if.slave bus
);

  // Packed element [7] holds BIRTHDAY[31:28], the first expected digit.
  localparam logic [7:0][3:0]   c_digits  = BIRTHDAY;
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;
  localparam logic [3:0]        c_bcd_max = 4'd9;

  logic [2:0]       r_pos;
  logic             r_match;
  logic             r_error;
  logic             r_locked;
  logic [CNT_W-1:0] r_match_count;

  logic [3:0]       w_expected;
  logic [3:0]       w_first;
  logic             w_is_bcd;

  assign w_expected = c_digits[3'd7 - r_pos];
  assign w_first    = c_digits[7];
  assign w_is_bcd   = (bus.digit <= c_bcd_max);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pos         <= 3'd0;
      r_match       <= 1'b0;
      r_error       <= 1'b0;
      r_locked      <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_match <= 1'b0;
      r_error <= 1'b0;
      if (bus.digit_valid) begin
        if (!w_is_bcd) begin
          r_error  <= 1'b1;
          r_pos    <= 3'd0;
          r_locked <= 1'b0;
        end else if (bus.digit == w_expected) begin
          if (r_pos == 3'd7) begin
            r_match  <= 1'b1;
            r_pos    <= 3'd0;
            r_locked <= 1'b1;
            if (r_match_count != c_cnt_max) begin
              r_match_count <= r_match_count + 1'b1;
            end
          end else begin
            r_pos <= r_pos + 3'd1;
          end
        end else begin
          // Single-step fallback: a mismatching digit may itself restart the sequence.
          r_pos    <= (bus.digit == w_first) ? 3'd1 : 3'd0;
          r_locked <= 1'b0;
        end
      end
    end
  end

  assign bus.pos         = r_pos;
  assign bus.match       = r_match;
  assign bus.error       = r_error;
  assign bus.locked      = r_locked;
  assign bus.match_count = r_match_count;

endmodule

`default_nettype wire

// File: tb/tb_birthday_digit_checker.sv
// Bench for birthday_digit_checker: directed scenarios plus random streams against a rule-level model.
`default_nettype none

module tb_birthday_digit_checker;

  localparam logic [31:0] BDAY = 32'h20010315;

  logic CLK;
  logic RST;

  birthday_digit_checker_if #(.CNT_W(8)) bus ();
  birthday_digit_checker_if #(.CNT_W(2)) bus_s ();

  birthday_digit_checker #(.BIRTHDAY(BDAY), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  birthday_digit_checker #(.BIRTHDAY(BDAY), .CNT_W(2)) dut_s (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_s.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_pos, m_cnt, m_cnt_s;
  bit m_match, m_error, m_locked;
  int n_match, n_match_s, n_error;

  function automatic int exp_digit(input int p);
    return int'((longint'(BDAY) >> (4 * (7 - p))) % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int d);
    if (r) begin
      m_pos = 0; m_match = 0; m_error = 0; m_locked = 0; m_cnt = 0; m_cnt_s = 0;
      return;
    end
    m_match = 0;
    m_error = 0;
    if (!v) return;
    if (d > 9) begin
      m_error = 1; m_pos = 0; m_locked = 0;
    end else if (d == exp_digit(m_pos)) begin
      if (m_pos == 7) begin
        m_match = 1; m_pos = 0; m_locked = 1;
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
      end else begin
        m_pos++;
      end
    end else begin
      m_pos = (d == exp_digit(0)) ? 1 : 0;
      m_locked = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input int d);
    RST = r;
    bus.digit_valid   = v;
    bus.digit         = 4'(d);
    bus_s.digit_valid = v;
    bus_s.digit       = 4'(d);
    @(posedge CLK);
    model_step(r, v, d);
    #1;
    check("pos", 32'(bus.pos), 32'(m_pos));
    check("match", 32'(bus.match), 32'(m_match));
    check("error", 32'(bus.error), 32'(m_error));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("match_count", 32'(bus.match_count), 32'(m_cnt));
    check("match_s", 32'(bus_s.match), 32'(m_match));
    check("match_count_s", 32'(bus_s.match_count), 32'(m_cnt_s));
    if (bus.match === 1'b1) n_match++;
    if (bus_s.match === 1'b1) n_match_s++;
    if (bus.error === 1'b1) n_error++;
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    n_match = 0; n_match_s = 0; n_error = 0;
  endtask

  task automatic feed_seq();
    for (int i = 0; i < 8; i++) step(0, 1, exp_digit(i));
  endtask

  initial begin
    int pre[10];
    int gap_cycles;
    int k;
    RST = 1'b1;
    bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus_s.digit_valid = 1'b0; bus_s.digit = 4'd0;
    @(posedge CLK); #1;

    // Reset state
    do_reset();
    check("reset_pos", 32'(bus.pos), 0);
    check("reset_count", 32'(bus.match_count), 0);

    // Single clean sequence
    feed_seq();
    check("seq1_matches", n_match, 1);
    check("seq1_count", 32'(bus.match_count), 1);
    check("seq1_locked", 32'(bus.locked), 1);
    step(0, 0, 0);
    check("seq1_pulse_end", 32'(bus.match), 0);

    // Three back-to-back loops, locked never drops
    do_reset();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        step(0, 1, exp_digit(i));
        if (s > 0) check("loop_locked", 32'(bus.locked), 1);
      end
    end
    check("loop_matches", n_match, 3);
    check("loop_count", 32'(bus.match_count), 3);

    // Mismatch with single-step fallback: 2,0,2,0,0,1,0,3,1,5
    do_reset();
    pre = '{2, 0, 2, 0, 0, 1, 0, 3, 1, 5};
    for (int i = 0; i < 10; i++) begin
      step(0, 1, pre[i]);
      if (i == 2) check("fallback_pos", 32'(bus.pos), 1);
    end
    check("fallback_matches", n_match, 1);

    // Non-BCD digit aborts progress
    do_reset();
    step(0, 1, 2); step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 4'hA);
    check("nonbcd_error", 32'(bus.error), 1);
    check("nonbcd_pos", 32'(bus.pos), 0);
    feed_seq();
    check("nonbcd_errors", n_error, 1);
    check("nonbcd_matches", n_match, 1);

    // Random gaps between digits
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, exp_digit(i));
      gap_cycles = int'($urandom_range(1, 3));
      for (int g = 0; g < gap_cycles; g++) step(0, 0, int'($urandom_range(0, 15)));
    end
    check("gap_matches", n_match, 1);
    check("gap_count", 32'(bus.match_count), 1);

    // Reset mid-stream with digit_valid high
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, exp_digit(i));
    step(1, 1, exp_digit(4));
    check("midrst_pos", 32'(bus.pos), 0);
    for (int i = 4; i < 8; i++) step(0, 1, exp_digit(i));
    check("midrst_nomatch", n_match, 0);
    feed_seq();
    check("midrst_matches", n_match, 1);

    // Saturation of the narrow counter
    do_reset();
    for (int s = 0; s < 5; s++) feed_seq();
    check("sat_pulses", n_match_s, 5);
    check("sat_count", 32'(bus_s.match_count), 3);
    check("wide_count", 32'(bus.match_count), 5);

    // Random stream biased towards the birthday digits
    do_reset();
    k = 0;
    for (int i = 0; i < 600; i++) begin
      bit v;
      int d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) != 0) ? exp_digit(k % 8) : int'($urandom_range(0, 15));
      if (v) k++;
      step(($urandom_range(0, 99) == 0), v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/birthday_digit_checker.md
Name: birthday_digit_checker

Overview:
- Receive-side counterpart of the birthday digit display. The display emits one 4-bit BCD digit per step of a wrapping 3-bit counter; this block consumes that digit stream and checks it against the expected 8-digit birthday.
- Tracks match progress and pulses on every complete, in-order 8-digit sequence. Flags non-BCD digits. Keeps a saturating count of complete matches for the lab testbench and LED/7-seg status.

Parameters:
- BIRTHDAY, 32'h20010315, expected 8 BCD digits. Digit 0 (first expected) is BIRTHDAY[31:28]; digit 7 is BIRTHDAY[3:0].
- CNT_W, 8, width of match_count.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- digit_valid  input  1  digit is presented this cycle.
- digit  input  4  BCD digit from the display side.
- match  output  1  one-cycle pulse: a full 8-digit sequence was just accepted.
- error  output  1  one-cycle pulse: a non-BCD digit (>9) was accepted.
- locked  output  1  high from a match until the next mismatch or error.
- pos  output  3  number of digits matched so far (0..7); the next expected digit is digit[pos].
- match_count  output  CNT_W  number of complete matches, saturating.

Behaviour:
- Reset:
  - RST high at a posedge sets pos=0, match=0, error=0, locked=0, match_count=0.
  - Reset has priority over digit_valid. Reset mid-sequence discards all partial progress.
- All outputs are registered. match and error assert in the cycle after the posedge that accepted the digit, and last exactly one cycle.
- digit_valid=0: pos, locked and match_count hold; match=0, error=0.
- digit_valid=1, evaluated in this order:
  - digit > 9: error<=1, pos<=0, locked<=0, no match. This takes precedence over compare.
  - digit == expected[pos] and pos<7: pos<=pos+1.
  - digit == expected[pos] and pos==7:
    - match<=1, pos<=0 (wraps), locked<=1.
    - match_count<=match_count+1, except it holds at 2^CNT_W-1.
  - digit != expected[pos]:
    - if digit == expected[0], pos<=1; otherwise pos<=0.
    - locked<=0.
    - This single-step fallback is the defined rule. Full prefix/KMP fallback is not required.
- Back-to-back sequences need no gap. After a match, the next accepted digit is compared against digit 0. A continuously looping display therefore yields one match every 8 valid digits.
- match_count increments only on match. error does not modify it.
- locked:
  - Set only on match.
  - Held across valid gaps and across correct partial progress.
  - Cleared on mismatch or error.
- Width rules: pos is 3-bit and wraps 7->0 only via the match path. The comparison is 4-bit unsigned equality.

Test Plan:
- Reset, then feed 2,0,0,1,0,3,1,5 with digit_valid=1 every cycle:
  - pos steps 0..7, then 0.
  - match=1 for the single cycle after the "5" edge.
  - match_count=1, locked=1.
- Loop the 8-digit stream 3 times with no gaps:
  - 3 match pulses, each 8 cycles apart.
  - match_count=3, locked stays 1 throughout.
- Feed 2,0,2,0,0,1,0,3,1,5:
  - The third digit (2) mismatches, so pos=1 and locked=0.
  - match fires after the 10th digit; match_count=1.
- Feed 2,0,0, then digit 4'hA, then 2,0,0,1,0,3,1,5:
  - error pulses once after 4'hA, pos=0.
  - match fires only after the final 5.
- Same 8-digit stream with digit_valid=0 for 1-3 random cycles between digits:
  - pos holds during the gaps.
  - A single match occurs; result is identical to the gapless run.
- Two scenarios, run separately:
  - Reset mid-stream: assert RST (together with digit_valid=1) after 4 correct digits; pos=0, and a full 8 further digits are needed to match.
  - Saturation: with CNT_W=2, run 5 complete sequences; match_count saturates at 3 while match still pulses 5 times.
